// File: rtl/router_reg_if.sv
// Bus between router_fsm/input side and the router_reg datapath stage.
// Optional err_cnt output present only when ROUTER_REG_ERR_CNT_EN is defined.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;
  logic [DATA_WIDTH-1:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_ERR_CNT_EN
    input  err_cnt,
`endif
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_ERR_CNT_EN
    output err_cnt,
`endif
    output parity_done, low_pkt_valid, err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router 1x3 datapath register: header/hold capture, running parity and error flag.
// Define ROUTER_REG_ERR_CNT_EN to add a saturating 8-bit parity error counter.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input logic        clock,
  input logic        reset,
  router_reg_if.slave bus
);
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_par_q, hold_par_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  pdone_q, pdone_d;
  logic                  lpv_q, lpv_d;
  logic                  err_q, err_d;

  always_comb begin
    dout_d     = dout_q;
    header_d   = header_q;
    hold_d     = hold_q;
    hold_par_d = hold_par_q;
    int_par_d  = int_par_q;
    pkt_par_d  = pkt_par_q;
    pdone_d    = pdone_q;
    lpv_d      = lpv_q;
    err_d      = err_q;

    // Strobes are one-hot from the FSM; the else-chain sets priority if not.
    if (bus.detect_add) begin
      if (bus.pkt_valid && bus.data_in[1:0] != 2'b11) header_d = bus.data_in;
      int_par_d = '0;
      pkt_par_d = '0;
      pdone_d   = 1'b0;
    end else if (bus.lfd_state) begin
      dout_d    = header_q;
      int_par_d = int_par_q ^ header_q;
    end else if (bus.ld_state) begin
      if (!bus.fifo_full) begin
        dout_d = bus.data_in;
        if (bus.pkt_valid) begin
          int_par_d = int_par_q ^ bus.data_in;
        end else begin
          pkt_par_d = bus.data_in;
          pdone_d   = 1'b1;
        end
      end else begin
        hold_d     = bus.data_in;
        hold_par_d = !bus.pkt_valid;
      end
      if (!bus.pkt_valid) lpv_d = 1'b1;
    end else if (bus.laf_state && !pdone_q) begin
      // Replay the byte parked while the FIFO was full; it may be the parity byte.
      dout_d = hold_q;
      if (hold_par_q) begin
        pkt_par_d = hold_q;
        pdone_d   = 1'b1;
      end else begin
        int_par_d = int_par_q ^ hold_q;
      end
    end

    if (bus.rst_int_reg) lpv_d = 1'b0;

    if (bus.detect_add)  err_d = 1'b0;
    else if (pdone_q)    err_d = (int_par_q != pkt_par_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q     <= '0;
      header_q   <= '0;
      hold_q     <= '0;
      hold_par_q <= 1'b0;
      int_par_q  <= '0;
      pkt_par_q  <= '0;
      pdone_q    <= 1'b0;
      lpv_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      header_q   <= header_d;
      hold_q     <= hold_d;
      hold_par_q <= hold_par_d;
      int_par_q  <= int_par_d;
      pkt_par_q  <= pkt_par_d;
      pdone_q    <= pdone_d;
      lpv_q      <= lpv_d;
      err_q      <= err_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = pdone_q;
  assign bus.low_pkt_valid = lpv_q;
  assign bus.err           = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && !err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_router_reg.sv
// Directed table-driven bench for router_reg, with extra bad-packet sequences
// (err_cnt checked when ROUTER_REG_ERR_CNT_EN is defined).
module tb_router_reg;
  localparam int DW = 8;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] DA   = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] FS   = 6'b000010;
  localparam logic [5:0] RIR  = 6'b000001;

  typedef struct {
    logic          rst;
    logic [5:0]    strb;
    logic          pv;
    logic          ff;
    logic [DW-1:0] din;
    logic [DW-1:0] e_dout;
    logic          e_pd;
    logic          e_lpv;
    logic          e_err;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  router_reg_if #(.DATA_WIDTH(DW)) bus ();
  router_reg #(.DATA_WIDTH(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic [5:0] strb, input logic pv,
                     input logic ff, input logic [7:0] din, input logic [7:0] e_dout,
                     input logic e_pd, input logic e_lpv, input logic e_err);
    vec_t v;
    v.rst = rst; v.strb = strb; v.pv = pv; v.ff = ff; v.din = din;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    reset          = v.rst;
    bus.detect_add = v.strb[5];
    bus.lfd_state  = v.strb[4];
    bus.ld_state   = v.strb[3];
    bus.laf_state  = v.strb[2];
    bus.full_state = v.strb[1];
    bus.rst_int_reg = v.strb[0];
    bus.pkt_valid  = v.pv;
    bus.fifo_full  = v.ff;
    bus.data_in    = v.din;
    @(posedge clock);
    #1;
    check({tag, "_dout"}, bus.dout, v.e_dout);
    check({tag, "_pdone"}, {7'd0, bus.parity_done}, {7'd0, v.e_pd});
    check({tag, "_lpv"}, {7'd0, bus.low_pkt_valid}, {7'd0, v.e_lpv});
    check({tag, "_err"}, {7'd0, bus.err}, {7'd0, v.e_err});
  endtask

  task automatic bad_packet(input string tag);
    vec_t v;
    v.rst = 0; v.ff = 0;
    v.strb = DA;  v.pv = 1; v.din = 8'h05; v.e_dout = bus.dout; v.e_pd = 0; v.e_lpv = 0; v.e_err = 0;
    step(v, {tag, "_da"});
    v.strb = LFD; v.pv = 1; v.din = 8'h00; v.e_dout = 8'h05; v.e_pd = 0; v.e_lpv = 0; v.e_err = 0;
    step(v, {tag, "_lfd"});
    v.strb = LD;  v.pv = 1; v.din = 8'hA3; v.e_dout = 8'hA3; v.e_pd = 0; v.e_lpv = 0; v.e_err = 0;
    step(v, {tag, "_ld"});
    v.strb = LD;  v.pv = 0; v.din = 8'hA7; v.e_dout = 8'hA7; v.e_pd = 1; v.e_lpv = 1; v.e_err = 0;
    step(v, {tag, "_lp"});
    v.strb = RIR; v.pv = 0; v.din = 8'h00; v.e_dout = 8'hA7; v.e_pd = 1; v.e_lpv = 0; v.e_err = 1;
    step(v, {tag, "_cpe"});
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //   rst strobe pv ff din    dout   pd lpv err
    add(1, NONE, 0, 0, 8'h00, 8'h00, 0, 0, 0);  // reset state
    add(0, DA,   1, 0, 8'h05, 8'h00, 0, 0, 0);  // good packet
    add(0, LFD,  1, 0, 8'hA3, 8'h05, 0, 0, 0);
    add(0, LD,   1, 0, 8'hA3, 8'hA3, 0, 0, 0);
    add(0, LD,   0, 0, 8'hA6, 8'hA6, 1, 1, 0);
    add(0, RIR,  0, 0, 8'h00, 8'hA6, 1, 0, 0);
    add(0, NONE, 0, 0, 8'h00, 8'hA6, 1, 0, 0);
    add(0, DA,   1, 0, 8'h05, 8'hA6, 0, 0, 0);  // bad parity
    add(0, LFD,  1, 0, 8'h00, 8'h05, 0, 0, 0);
    add(0, LD,   1, 0, 8'hA3, 8'hA3, 0, 0, 0);
    add(0, LD,   0, 0, 8'hA7, 8'hA7, 1, 1, 0);
    add(0, RIR,  0, 0, 8'h00, 8'hA7, 1, 0, 1);
    add(0, NONE, 0, 0, 8'h00, 8'hA7, 1, 0, 1);
    add(0, NONE, 0, 0, 8'h00, 8'hA7, 1, 0, 1);
    add(0, DA,   1, 0, 8'h06, 8'hA7, 0, 0, 0);  // full mid-payload
    add(0, LFD,  1, 0, 8'h00, 8'h06, 0, 0, 0);
    add(0, LD,   1, 0, 8'h11, 8'h11, 0, 0, 0);
    add(0, LD,   1, 1, 8'h3C, 8'h11, 0, 0, 0);
    add(0, FS,   1, 1, 8'h00, 8'h11, 0, 0, 0);
    add(0, LAF,  1, 0, 8'h00, 8'h3C, 0, 0, 0);
    add(0, LD,   0, 0, 8'h2B, 8'h2B, 1, 1, 0);
    add(0, RIR,  0, 0, 8'h00, 8'h2B, 1, 0, 0);
    add(0, DA,   1, 0, 8'h01, 8'h2B, 0, 0, 0);  // full on parity byte
    add(0, LFD,  1, 0, 8'h00, 8'h01, 0, 0, 0);
    add(0, LD,   1, 0, 8'h50, 8'h50, 0, 0, 0);
    add(0, LD,   0, 1, 8'h51, 8'h50, 0, 1, 0);
    add(0, FS,   0, 1, 8'h00, 8'h50, 0, 1, 0);
    add(0, LAF,  0, 0, 8'h00, 8'h51, 1, 1, 0);
    add(0, RIR,  0, 0, 8'h00, 8'h51, 1, 0, 0);
    add(0, LAF,  0, 0, 8'h00, 8'h51, 1, 0, 0);  // LAF with parity already done
    add(0, DA,   1, 0, 8'h07, 8'h51, 0, 0, 0);  // address 2'b11 ignored
    add(0, LFD,  1, 0, 8'h00, 8'h01, 0, 0, 0);
    add(0, LD,   1, 0, 8'h22, 8'h22, 0, 0, 0);
    add(1, LD,   1, 0, 8'h44, 8'h00, 0, 0, 0);  // reset mid-payload
    add(0, DA,   1, 0, 8'h02, 8'h00, 0, 0, 0);
    add(0, LFD,  1, 0, 8'h00, 8'h02, 0, 0, 0);
    add(0, LD,   1, 0, 8'h10, 8'h10, 0, 0, 0);
    add(0, LD,   0, 0, 8'h12, 8'h12, 1, 1, 0);
    add(0, RIR,  0, 0, 8'h00, 8'h12, 1, 0, 0);
    add(0, LD|RIR, 0, 0, 8'h12, 8'h12, 1, 0, 0);  // clear beats set
    add(0, DA|LFD, 1, 0, 8'h09, 8'h12, 0, 0, 0);  // detect_add wins
    add(0, LFD,  1, 0, 8'h00, 8'h09, 0, 0, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      step(v, $sformatf("row%0d", i));
    end

    bad_packet("bad1");
    bad_packet("bad2");
`ifdef ROUTER_REG_ERR_CNT_EN
    check("err_cnt_two", bus.err_cnt, 8'd2);
`endif
    v.rst = 0; v.strb = DA; v.pv = 1; v.ff = 0; v.din = 8'h05;
    v.e_dout = 8'hA7; v.e_pd = 0; v.e_lpv = 0; v.e_err = 0;
    step(v, "da_clears_err");
`ifdef ROUTER_REG_ERR_CNT_EN
    check("err_cnt_kept", bus.err_cnt, 8'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
